rst_seq_ctrl: RTL and testbench
===============================

# rst_seq_ctrl

Reset sequencing controller for the system's clock domains. It takes the board-level asynchronous reset and a software reset request, and releases one reset line per downstream domain in a fixed, spaced order (domain 0 first). Each released line then goes through that domain's own reset synchronizer. The block sits at the top of the system, between the reset pin and the per-domain synchronizers, and reports when the whole system is out of reset.

## Interface
- NUM_DOMAINS, 4: number of sequenced reset outputs; legal range 1..16.
- CNT_WIDTH, 8: width of the gap counter and of HOLD_CYCLES.
- SYNC_STAGES, 2: flops used internally to synchronize RST deassertion; minimum 2.

- RST  in  1  asynchronous, active-low reset.
- CLK  in  1  controller clock.
- SW_RST_REQ  in  1  synchronous software reset request, level-sampled each CLK edge.
- HOLD_CYCLES  in  CNT_WIDTH  gap length minus one, between consecutive releases.
- DOMAIN_RST_N  out  NUM_DOMAINS  per-domain reset, active-low; bit i drives domain i.
- SEQ_DONE  out  1  high once all domains are released.
- SW_RST_ACK  out  1  one-cycle pulse acknowledging an accepted SW_RST_REQ.

## Operation
- RST low forces, asynchronously:
  - DOMAIN_RST_N = all 0, SEQ_DONE = 0, SW_RST_ACK = 0;
  - the internal sync chain clears, state = SYNC_WAIT, domain index = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - SYNC_WAIT: waits for RST deassertion to pass through the SYNC_STAGES chain.
  - SW_HOLD: holds all domains in reset for HOLD_CYCLES+1 cycles after a software request.
  - GAP: counts down between releases.
  - DONE: all domains released.
- Transitions:
  - SYNC_WAIT -> GAP when the sync chain output goes high. The counter loads HOLD_CYCLES and the index is 0.
  - GAP: the counter decrements each cycle. When the count is 0:
    - set DOMAIN_RST_N[index];
    - if index = NUM_DOMAINS-1, go to DONE; otherwise increment index, reload HOLD_CYCLES and stay in GAP.
  - DONE: SEQ_DONE = 1.
  - SW_HOLD -> GAP when its counter reaches 0. The counter reloads and the index is 0.
- Software reset:
  - SW_RST_REQ is sampled high in GAP, SW_HOLD or DONE. Not in SYNC_WAIT, where it is ignored.
  - On that edge: DOMAIN_RST_N = all 0, SEQ_DONE = 0, SW_RST_ACK = 1 for one cycle, counter loads HOLD_CYCLES, state = SW_HOLD.
  - A request during GAP or SW_HOLD restarts the sequence from scratch.
  - If SW_RST_REQ is held high, it re-triggers every cycle. Stay in SW_HOLD with ACK high each cycle; software must pulse the request.
- Released bits stay high until RST or an accepted SW_RST_REQ. Bits never release out of order.
- HOLD_CYCLES is sampled only at counter load. A change mid-gap takes effect at the next load.
- HOLD_CYCLES = 0 gives a 1-cycle gap, which is legal.

## Timing
- Edge 1 is the first CLK rising edge with RST high; H = HOLD_CYCLES.
- Power-on release:
  - DOMAIN_RST_N[i] rises after edge SYNC_STAGES + (i+1)(H+1).
  - SEQ_DONE rises after edge SYNC_STAGES + NUM_DOMAINS(H+1) + 1.
- Software reset, request accepted at edge t:
  - all outputs low and ACK high after edge t; ACK low after edge t+1;
  - DOMAIN_RST_N[i] rises after edge t + (i+2)(H+1);
  - SEQ_DONE rises one edge after the last release.
- RST assertion mid-sequence aborts immediately and asynchronously. The next deassertion restarts from SYNC_WAIT.

## Structure
- Shared package rst_seq_pkg holds:
  - state encoding localparams (SYNC_WAIT, SW_HOLD, GAP, DONE);
  - the index width, clog2 of NUM_DOMAINS with a minimum of 1.
- One sub-module, rst_gap_timer: a loadable CNT_WIDTH down-counter with a load input, an enable input and a zero flag. It is shared by SW_HOLD and GAP.
- The sync chain, FSM, index counter and output register stay in rst_seq_ctrl.

## Test plan
- Power-on, NUM_DOMAINS=4, H=3, SYNC_STAGES=2 -> releases after edges 6, 10, 14, 18; SEQ_DONE after edge 19; ACK never high.
- H=0 -> releases after edges 3, 4, 5, 6; SEQ_DONE after edge 7.
- In DONE with H=3, a 1-cycle SW_RST_REQ at edge t -> all outputs low and ACK pulse at t; releases at t+8, t+12, t+16, t+20; SEQ_DONE at t+21.
- SW_RST_REQ pulsed after domain 1 has released, mid-GAP -> both released bits drop at that edge and the sequence restarts per the software timing.
- RST pulsed low while domain 2 is pending -> immediate all-zero outputs; after deassertion, the power-on timing is repeated exactly.
- HOLD_CYCLES changed from 3 to 7 mid-gap -> the current gap stays 4 cycles and the next gap is 8 cycles; SW_RST_REQ held high during SYNC_WAIT -> ignored, with no ACK.

Source files
------------

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: state encoding and index sizing.
// Imported by the sequencer top and its gap timer.
package rst_seq_pkg;

  localparam logic [1:0] ST_SYNC_WAIT = 2'd0;
  localparam logic [1:0] ST_SW_HOLD   = 2'd1;
  localparam logic [1:0] ST_GAP       = 2'd2;
  localparam logic [1:0] ST_DONE      = 2'd3;

  typedef enum logic [1:0] {
    SYNC_WAIT = ST_SYNC_WAIT,
    SW_HOLD   = ST_SW_HOLD,
    GAP       = ST_GAP,
    DONE      = ST_DONE
  } seq_state_e;

  // A single domain still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Software/system-facing signals of the reset sequencer.
// The controller uses the slave modport; the system side uses master.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_WIDTH   = 8
);

  logic                   SW_RST_REQ;
  logic [CNT_WIDTH-1:0]   HOLD_CYCLES;
  logic [NUM_DOMAINS-1:0] DOMAIN_RST_N;
  logic                   SEQ_DONE;
  logic                   SW_RST_ACK;

  modport master (
    output SW_RST_REQ,
    output HOLD_CYCLES,
    input  DOMAIN_RST_N,
    input  SEQ_DONE,
    input  SW_RST_ACK
  );

  modport slave (
    input  SW_RST_REQ,
    input  HOLD_CYCLES,
    output DOMAIN_RST_N,
    output SEQ_DONE,
    output SW_RST_ACK
  );

endinterface

// File: rtl/rst_seq_ctrl_gap_timer.sv
// Loadable down-counter shared by the software hold and the inter-release gaps.
// Load wins over enable; the count parks at zero.
module rst_gap_timer
  import rst_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes board reset release, then releases one
// active-low reset per domain in order, spaced by HOLD_CYCLES+1 cycles.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          RST,
  input  logic          CLK,
  rst_seq_ctrl_if.slave bus
);

  localparam int               IDX_W    = idx_width(NUM_DOMAINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;
  logic                   tmr_load, tmr_en, tmr_zero;
  logic [SYNC_STAGES-2:0] sync_q;
  logic                   rst_ok;

  // The state flop leaving SYNC_WAIT is the last stage of the release synchronizer.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rst_ok = sync_q[SYNC_STAGES-2];

  rst_gap_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_gap_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (bus.HOLD_CYCLES),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= SYNC_WAIT;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dom_d    = dom_q;
    ack_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      SYNC_WAIT: begin
        if (rst_ok) begin
          state_d  = GAP;
          idx_d    = '0;
          tmr_load = 1'b1;
        end
      end
      SW_HOLD: begin
        if (tmr_zero) begin
          state_d  = GAP;
          idx_d    = '0;
          tmr_load = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          dom_d[idx_q] = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = SYNC_WAIT;
      end
    endcase

    // An accepted software request overrides whatever the sequence was doing.
    if (bus.SW_RST_REQ && (state_q != SYNC_WAIT)) begin
      state_d  = SW_HOLD;
      idx_d    = '0;
      dom_d    = '0;
      ack_d    = 1'b1;
      tmr_load = 1'b1;
      tmr_en   = 1'b0;
    end

    done_d = (state_q == DONE) && !ack_d;
  end

  assign bus.DOMAIN_RST_N = dom_q;
  assign bus.SEQ_DONE     = done_q;
  assign bus.SW_RST_ACK   = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected per-edge snapshots are queued as
// stimulus is applied and popped when the matching edge has been sampled.
module tb_rst_seq_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int S  = 2;

  typedef struct packed {
    int           cyc;
    logic [N-1:0] dom;
    logic         done;
    logic         ack;
  } exp_t;

  logic  CLK;
  logic  RST;
  int    edge_cnt;
  int    tests_run;
  int    fail_cnt;
  string phase;
  exp_t  exp_q[$];

  rst_seq_ctrl_if #(.NUM_DOMAINS(N), .CNT_WIDTH(CW)) bus ();

  rst_seq_ctrl #(
    .NUM_DOMAINS (N),
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (S)
  ) dut (
    .RST (RST),
    .CLK (CLK),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic apply_stimulus(input logic rst_v, input logic req_v, input logic [CW-1:0] hold_v);
    RST             = rst_v;
    bus.SW_RST_REQ  = req_v;
    bus.HOLD_CYCLES = hold_v;
  endtask

  // origin: edge at which the first gap counter is loaded; h0 sizes the first
  // gap, h1 every later gap; ack is expected high for edges ack_from..ack_to.
  task automatic push_seq(input int origin, input int h0, input int h1,
                          input int from_e, input int to_e,
                          input int ack_from, input int ack_to);
    exp_t x;
    for (int e = from_e; e <= to_e; e++) begin
      x.cyc = e;
      x.dom = '0;
      for (int i = 0; i < N; i++) begin
        if (e >= origin + (h0 + 1) + i * (h1 + 1)) x.dom[i] = 1'b1;
      end
      x.done = (e >= origin + (h0 + 1) + (N - 1) * (h1 + 1) + 1);
      x.ack  = (e >= ack_from) && (e <= ack_to);
      exp_q.push_back(x);
    end
  endtask

  task automatic check_output();
    exp_t x;
    while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
      x = exp_q.pop_front();
      tests_run++;
      assert ({bus.DOMAIN_RST_N, bus.SEQ_DONE, bus.SW_RST_ACK} === {x.dom, x.done, x.ack})
      else begin
        fail_cnt++;
        $error("FAIL %s edge %0d: observed dom=%b done=%b ack=%b, expected dom=%b done=%b ack=%b",
               phase, x.cyc, bus.DOMAIN_RST_N, bus.SEQ_DONE, bus.SW_RST_ACK, x.dom, x.done, x.ack);
      end
    end
  endtask

  task automatic check_now(input string tag);
    tests_run++;
    assert ({bus.DOMAIN_RST_N, bus.SEQ_DONE, bus.SW_RST_ACK} === {{N{1'b0}}, 2'b00})
    else begin
      fail_cnt++;
      $error("FAIL %s: observed dom=%b done=%b ack=%b, expected all zero",
             tag, bus.DOMAIN_RST_N, bus.SEQ_DONE, bus.SW_RST_ACK);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      edge_cnt++;
      check_output();
    end
  endtask

  task automatic run_until_empty(input int budget);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      step(1);
      b--;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      fail_cnt++;
      $display("FAIL %s timeout: %0d expectations left, required 0", phase, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int e0, t, t1, t2;
    edge_cnt  = 0;
    tests_run = 0;
    fail_cnt  = 0;

    phase = "reset";
    apply_stimulus(1'b0, 1'b0, 8'd3);
    step(3);
    check_now("reset_state");

    // Power-on, aborted by RST while domain 2 is pending.
    phase = "abort";
    apply_stimulus(1'b1, 1'b0, 8'd3);
    e0 = edge_cnt;
    push_seq(e0 + S, 3, 3, e0 + 1, e0 + 11, -1, -2);
    run_until_empty(40);
    apply_stimulus(1'b0, 1'b0, 8'd3);
    #2;
    check_now("async_abort");
    step(2);
    check_now("reset_held");

    phase = "poweron_h3";
    apply_stimulus(1'b1, 1'b0, 8'd3);
    e0 = edge_cnt;
    push_seq(e0 + S, 3, 3, e0 + 1, e0 + 22, -1, -2);
    run_until_empty(40);

    phase = "sw_in_done";
    apply_stimulus(1'b1, 1'b1, 8'd3);
    t = edge_cnt + 1;
    push_seq(t + 4, 3, 3, t, t + 23, t, t);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'd3);
    run_until_empty(40);

    // Second request lands mid-gap after domains 0 and 1 are released.
    phase = "sw_mid_gap";
    apply_stimulus(1'b1, 1'b1, 8'd3);
    t1 = edge_cnt + 1;
    t2 = t1 + 14;
    push_seq(t1 + 4, 3, 3, t1, t2 - 1, t1, t1);
    push_seq(t2 + 4, 3, 3, t2, t2 + 23, t2, t2);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'd3);
    step(13);
    apply_stimulus(1'b1, 1'b1, 8'd3);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'd3);
    run_until_empty(40);

    phase = "sw_held";
    apply_stimulus(1'b1, 1'b1, 8'd3);
    t = edge_cnt + 1;
    push_seq(t + 2 + 4, 3, 3, t, t + 25, t, t + 2);
    step(3);
    apply_stimulus(1'b1, 1'b0, 8'd3);
    run_until_empty(40);

    phase = "poweron_h0";
    apply_stimulus(1'b0, 1'b0, 8'd0);
    #2;
    check_now("reset_before_h0");
    step(2);
    apply_stimulus(1'b1, 1'b0, 8'd0);
    e0 = edge_cnt;
    push_seq(e0 + S, 0, 0, e0 + 1, e0 + 9, -1, -2);
    run_until_empty(20);

    // Request held through SYNC_WAIT is ignored; HOLD_CYCLES changes mid-gap.
    phase = "syncwait_req_hold_change";
    apply_stimulus(1'b0, 1'b1, 8'd3);
    step(2);
    apply_stimulus(1'b1, 1'b1, 8'd3);
    e0 = edge_cnt;
    push_seq(e0 + S, 3, 7, e0 + 1, e0 + 33, -1, -2);
    step(2);
    apply_stimulus(1'b1, 1'b0, 8'd3);
    step(1);
    apply_stimulus(1'b1, 1'b0, 8'd7);
    run_until_empty(40);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
